fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one synchronous FIFO write port among `NUM_REQ` producers.
- Handshake per requester: each requester presents a beat with `req`/`req_data`; the arbiter grants at most one beat per cycle and forwards it through a registered `wen`/`wdata` stage to the FIFO.
- Back-pressure comes from the FIFO's `full` and `count`.
- Sits directly in front of the `fifo` write side; the `fifo` read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one registered FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_LOCK_EN to hold the grant on one requester until its req_last beat closes the packet.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 32,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wen,
   output logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          full,
   input  logic [ADDR_WIDTH-1:0]         count,
   output logic [$clog2(NUM_REQ)-1:0]    owner
);

   localparam int                    IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]        NREQ     = (IDX_W + 1)'(NUM_REQ);
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(FIFO_DEPTH - 1);

   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic                  wen_q, wen_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  space;
   logic                  rr_vld;
   logic [IDX_W-1:0]      rr_idx;
   logic [IDX_W:0]        rr_sum;
   logic                  win_vld;
   logic [IDX_W-1:0]      win_idx;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  take;

   // The registered beat still counts against the FIFO; same-cycle reads are not credited.
   assign space = !full && !(wen_q && (count == CNT_LAST));

   always_comb begin : rr_search
      rr_vld = 1'b0;
      rr_idx = '0;
      rr_sum = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         rr_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
         if (rr_sum >= NREQ) begin
            rr_sum = rr_sum - NREQ;
         end
         if (!rr_vld && req[rr_sum[IDX_W-1:0]]) begin
            rr_vld = 1'b1;
            rr_idx = rr_sum[IDX_W-1:0];
         end
      end
   end

`ifdef FIFO_ARB_LOCK_EN
   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] lock_id_q, lock_id_d;

   always_comb begin : lock_select
      win_vld = rr_vld;
      win_idx = rr_idx;
      if (state_q == ST_LOCKED) begin
         win_vld = req[lock_id_q];
         win_idx = lock_id_q;
      end
   end

   always_comb begin : lock_next
      state_d   = state_q;
      lock_id_d = lock_id_q;
      if (take) begin
         if (req_last[win_idx]) begin
            state_d = ST_ARB;
         end else begin
            state_d   = ST_LOCKED;
            lock_id_d = win_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_ARB;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end
`else
   logic unused_req_last;
   assign unused_req_last = ^req_last;
   assign win_vld         = rr_vld;
   assign win_idx         = rr_idx;
`endif

   assign take = rst_n && space && win_vld;

   always_comb begin : grant_decode
      gnt      = '0;
      win_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == win_idx) begin
            gnt[k]   = take;
            win_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin : out_next
      ptr_d   = ptr_q;
      owner_d = owner_q;
      wen_d   = 1'b0;
      wdata_d = wdata_q;
      if (take) begin
         ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
         owner_d = win_idx;
         wen_d   = 1'b1;
         wdata_d = win_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
      end
   end

   assign wen   = wen_q;
   assign wdata = wdata_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a queue-based FIFO plus a round-robin reference model of the arbiter.
module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_last = '0;
   logic [N-1:0]    gnt;
   logic            wen;
   logic [DW-1:0]   wdata;
   logic            full = 1'b0;
   logic [AW-1:0]   count = '0;
   logic [1:0]      owner;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(DEPTH),
      .ADDR_WIDTH(AW)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .req_data(req_data),
      .req_last(req_last),
      .gnt     (gnt),
      .wen     (wen),
      .wdata   (wdata),
      .full    (full),
      .count   (count),
      .owner   (owner)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference state: requester beats, FIFO contents, expected output register and rotation pointer.
   bit            pend[N];
   logic [DW-1:0] pdat[N];
   bit            plast[N];
   logic [DW-1:0] fifo[$];
   logic [DW-1:0] sent[$];
   bit            ex_wen   = 1'b0;
   logic [DW-1:0] ex_wdata = '0;
   int            ex_owner = 0;
   int            ptr_m    = 0;
   bit            locked   = 1'b0;
   int            lock_id  = 0;
   bit            fixed_data = 1'b0;
   int            req_pct    = 70;

   function automatic int pick();
`ifdef FIFO_ARB_LOCK_EN
      if (locked) return pend[lock_id] ? lock_id : -1;
`endif
      for (int k = 0; k < N; k++) begin
         if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
      end
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req[i]               = pend[i];
         req_data[i*DW +: DW] = pdat[i];
         req_last[i]          = plast[i];
      end
      full  = (fifo.size() >= DEPTH);
      count = AW'(fifo.size());
   endtask

   task automatic refill();
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && ($urandom_range(99) < req_pct)) begin
            pend[i]  = 1'b1;
            pdat[i]  = fixed_data ? DW'(i) : DW'($urandom);
            plast[i] = fixed_data ? 1'b1 : 1'($urandom_range(1));
         end
      end
   endtask

   task automatic step(input int rd_pct, input bit rst_val);
      int            w;
      bit            sp;
      logic [N-1:0]  eg;
      bit            wen_s;
      logic [DW-1:0] wd_s;
      logic [DW-1:0] rd_v;
      bit            do_rd;
      rst_n = rst_val;
      drive_inputs();
      @(negedge clk);
      sp = (fifo.size() < DEPTH) && !(ex_wen && fifo.size() == DEPTH - 1);
      w  = (rst_val && sp) ? pick() : -1;
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      check("gnt", 32'(gnt), 32'(eg));
      wen_s = wen;
      wd_s  = wdata;
      do_rd = (fifo.size() > 0) && ($urandom_range(99) < rd_pct);
      @(posedge clk);
      #1;
      if (!rst_val) begin
         fifo.delete();
         sent.delete();
         ex_wen   = 1'b0;
         ex_wdata = '0;
         ex_owner = 0;
         ptr_m    = 0;
         locked   = 1'b0;
      end else begin
         if (wen_s) check("no_overflow", 32'(fifo.size() < DEPTH), 32'd1);
         if (do_rd) begin
            rd_v = fifo.pop_front();
            if (sent.size() > 0) check("fifo_rdata", 32'(rd_v), 32'(sent.pop_front()));
            else check("fifo_rdata_extra", 32'd1, 32'd0);
         end
         if (wen_s && fifo.size() < DEPTH) fifo.push_back(wd_s);
         if (w >= 0) begin
            ex_wen   = 1'b1;
            ex_wdata = pdat[w];
            ex_owner = w;
            ptr_m    = (w + 1) % N;
            sent.push_back(pdat[w]);
`ifdef FIFO_ARB_LOCK_EN
            if (plast[w]) locked = 1'b0;
            else begin
               locked  = 1'b1;
               lock_id = w;
            end
`endif
            pend[w] = 1'b0;
         end else begin
            ex_wen = 1'b0;
         end
      end
      check("wen", 32'(wen), 32'(ex_wen));
      check("wdata", 32'(wdata), 32'(ex_wdata));
      check("owner", 32'(owner), 32'(ex_owner));
      refill();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i]  = 1'b1;
         pdat[i]  = DW'(8'hA0 + i);
         plast[i] = 1'b1;
      end
      // Reset held for two edges with every requester asserting.
      step(0, 1'b0);
      step(0, 1'b0);

      // Continuous requests with data equal to requester index: strict 0,1,2,3 rotation.
      fixed_data = 1'b1;
      req_pct    = 100;
      for (int i = 0; i < N; i++) begin
         pend[i]  = 1'b1;
         pdat[i]  = DW'(i);
         plast[i] = 1'b1;
      end
      for (int c = 0; c < 12; c++) step(100, 1'b1);

      // Starved reads fill the FIFO and exercise the count==DEPTH-1 / full blocking.
      fixed_data = 1'b0;
      req_pct    = 80;
      for (int c = 0; c < 150; c++) step(4, 1'b1);
      for (int c = 0; c < 100; c++) step(50, 1'b1);

      // Reset in the middle of traffic, then sparse random requests.
      step(50, 1'b0);
      req_pct = 30;
      for (int c = 0; c < 150; c++) step(60, 1'b1);
      req_pct = 90;
      for (int c = 0; c < 150; c++) step(20, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
